// File: rtl/shift_pipe_stage.sv
// Two-entry valid/ready pipeline around a 32-bit shifter (SLL/SRL/SRA/ROL).
// Stage 1 holds the operands; stage 2 holds the result and its zero/carry flags.
module shift_pipe_stage #(
  parameter int unsigned N    = 32,
  parameter int unsigned SHW  = 5,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  input  logic [1:0]      in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_z,
  output logic            out_zero,
  output logic            out_carry,
  output logic [CNTW-1:0] done_count
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  logic           s1_valid;
  logic [N-1:0]   s1_a;
  logic [SHW-1:0] s1_sh;
  op_e            s1_op;
  logic           s2_valid;

  logic           s2_take;
  logic           accept;
  logic [N-1:0]   res_c;
  logic           carry_c;
  logic [N:0]     lsh_ext;
  logic [N:0]     rsh_ext;
  logic [2*N-1:0] rol_ext;

  // Upper shift-amount bits are architecturally ignored.
  logic unused_b;
  assign unused_b = ^in_b[N-1:SHW];

  assign s2_take   = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~rst & (~s1_valid | s2_take);
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;

  // Extended operands expose the last bit shifted out at a fixed position.
  assign lsh_ext = {1'b0, s1_a} << s1_sh;
  assign rsh_ext = {s1_a, 1'b0} >> s1_sh;
  assign rol_ext = {s1_a, s1_a} << s1_sh;

  always_comb begin
    res_c   = s1_a;
    carry_c = 1'b0;
    unique case (s1_op)
      OP_SLL: begin
        res_c   = s1_a << s1_sh;
        carry_c = lsh_ext[N];
      end
      OP_SRL: begin
        res_c   = s1_a >> s1_sh;
        carry_c = rsh_ext[0];
      end
      OP_SRA: begin
        res_c   = N'($signed(s1_a) >>> s1_sh);
        carry_c = rsh_ext[0];
      end
      OP_ROL: begin
        res_c   = rol_ext[2*N-1:N];
        carry_c = (s1_sh != '0) & rol_ext[N];
      end
      default: begin
        res_c   = s1_a;
        carry_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_sh      <= '0;
      s1_op      <= OP_SLL;
      s2_valid   <= 1'b0;
      out_z      <= '0;
      out_zero   <= 1'b0;
      out_carry  <= 1'b0;
      done_count <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= in_a;
        s1_sh    <= in_b[SHW-1:0];
        s1_op    <= op_e'(in_op);
      end else if (s2_take) begin
        s1_valid <= 1'b0;
      end

      // Result registers move only on a stage-2 load and otherwise hold.
      if (s2_take) begin
        s2_valid  <= 1'b1;
        out_z     <= res_c;
        out_zero  <= (res_c == '0);
        out_carry <= carry_c;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end

      if (s2_valid & out_ready) begin
        done_count <= done_count + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe_stage.sv
// Scoreboard bench for shift_pipe_stage: stimulus pushes reference results,
// a negedge monitor pops them as the DUT delivers and checks handshake rules.
module tb_shift_pipe_stage;

  localparam int unsigned N    = 32;
  localparam int unsigned CNTW = 4;

  typedef struct packed {
    logic [31:0] z;
    logic        zero;
    logic        carry;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_a;
  logic [N-1:0]    in_b;
  logic [1:0]      in_op;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_z;
  logic            out_zero;
  logic            out_carry;
  logic [CNTW-1:0] done_count;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   exp_cnt  = 0;

  shift_pipe_stage #(.N(N), .SHW(5), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_zero(out_zero), .out_carry(out_carry),
    .done_count(done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: shift one bit at a time, remembering the last bit that fell off.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    exp_t        r;
    logic [31:0] v;
    logic        c;
    int          sh;
    v  = a;
    c  = 1'b0;
    sh = int'(b[4:0]);
    for (int i = 0; i < sh; i++) begin
      case (op)
        2'd0:    begin c = v[31]; v = {v[30:0], 1'b0};  end
        2'd1:    begin c = v[0];  v = {1'b0, v[31:1]};  end
        2'd2:    begin c = v[0];  v = {v[31], v[31:1]}; end
        default: begin c = v[31]; v = {v[30:0], v[31]}; end
      endcase
    end
    r.z     = v;
    r.zero  = (v == 32'd0);
    r.carry = c;
    return r;
  endfunction

  // Monitor: occupancy model (queue size) predicts in_ready; results popped in order.
  logic        prev_ok = 1'b0;
  logic        prev_valid, prev_ready, prev_zero, prev_carry;
  logic [31:0] prev_z;
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_reset", 32'(in_ready), 32'd0);
    end else begin
      chk("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
      if (exp_q.size() == 0) chk("out_valid_empty", 32'(out_valid), 32'd0);
      if (prev_ok && prev_valid && !prev_ready) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_z", out_z, prev_z);
        chk("hold_flags", {30'd0, out_zero, out_carry}, {30'd0, prev_zero, prev_carry});
      end else if (prev_ok && !out_valid) begin
        chk("idle_z", out_z, prev_z);
        chk("idle_flags", {30'd0, out_zero, out_carry}, {30'd0, prev_zero, prev_carry});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_z", out_z, e.z);
          chk("out_zero", 32'(out_zero), 32'(e.zero));
          chk("out_carry", 32'(out_carry), 32'(e.carry));
        end
        chk("done_count", 32'(done_count), 32'(exp_cnt));
        exp_cnt = (exp_cnt + 1) % (1 << CNTW);
      end
    end
    prev_ok    = !rst;
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_z     = out_z;
    prev_zero  = out_zero;
    prev_carry = out_carry;
  end

  // All tasks start and end at posedge+1.
  task automatic do_reset(input int cycles);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    exp_q.delete();
    exp_cnt = 0;
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input int budget, input bit rand_ready, output bit acc);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    acc      = 1'b0;
    for (int t = 0; t < budget && !acc; t++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) exp_q.push_back(model(a, b, op));
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_ok(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    bit acc;
    send(a, b, op, 50, 1'b0, acc);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 2'd0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_z", out_z, 32'd0);
    chk("rst_flags", {30'd0, out_zero, out_carry}, 32'd0);
    chk("rst_done_count", 32'(done_count), 32'd0);
    @(posedge clk);
    #1;

    // Single op, then op and flag coverage.
    out_ready = 1'b1;
    send_ok(32'h0000_0001, 32'd4, 2'd0);
    drain();
    chk("first_done_count", 32'(done_count), 32'd1);
    send_ok(32'h8000_0000, 32'd31, 2'd2);
    send_ok(32'h8000_0001, 32'd1, 2'd1);
    send_ok(32'h8000_0001, 32'd1, 2'd3);
    send_ok(32'h8000_0000, 32'd1, 2'd0);
    send_ok(32'h1234_5678, 32'h0000_0020, 2'd3);
    send_ok(32'h8765_4321, 32'h0000_0020, 2'd2);
    send_ok(32'h8000_0001, 32'd31, 2'd3);
    send_ok(32'hF000_000F, 32'd31, 2'd0);
    drain();

    // Back-to-back streaming.
    for (int i = 0; i < 8; i++) send_ok(32'd1, 32'(i), 2'd0);
    drain();
    chk("stream_done_count", 32'(done_count), 32'(exp_cnt));

    // Backpressure: only two entries fit.
    out_ready = 1'b0;
    send(32'hA5A5_0001, 32'd3, 2'd0, 1, 1'b0, acc);
    chk("bp_acc1", 32'(acc), 32'd1);
    send(32'hA5A5_0002, 32'd4, 2'd1, 1, 1'b0, acc);
    chk("bp_acc2", 32'(acc), 32'd1);
    send(32'hA5A5_0003, 32'd5, 2'd2, 1, 1'b0, acc);
    chk("bp_acc3", 32'(acc), 32'd0);
    idle(3);
    send(32'hA5A5_0003, 32'd5, 2'd2, 1, 1'b0, acc);
    chk("bp_acc3_retry_blocked", 32'(acc), 32'd0);
    out_ready = 1'b1;
    send_ok(32'hA5A5_0003, 32'd5, 2'd2);
    drain();

    // Reset mid-flight discards both entries.
    out_ready = 1'b0;
    send_ok(32'h0000_00FF, 32'd1, 2'd0);
    send_ok(32'h0000_00FE, 32'd2, 2'd0);
    do_reset(1);
    out_ready = 1'b1;
    idle(4);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_done_count", 32'(done_count), 32'd0);

    // Counter wrap at 2^CNTW.
    for (int i = 0; i < 17; i++) send_ok($urandom, $urandom, 2'($urandom_range(0, 3)));
    drain();
    chk("wrap_done_count", 32'(done_count), 32'd1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        send($urandom, $urandom, 2'($urandom_range(0, 3)), 60, 1'b1, acc);
        if (!acc) chk("rand_accept_timeout", 32'd0, 32'd1);
      end else begin
        out_ready = ($urandom_range(0, 1) != 0);
        idle(1);
      end
    end
    drain();
    chk("final_done_count", 32'(done_count), 32'(exp_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
